// File: rtl/ctrl_sequencer_pkg.sv
// Shared types for the control sequencer: opcodes, FSM states, instruction
// field positions and the decoded control bundle.
package ctrl_pkg;

    localparam int OPC_MSB = 8;
    localparam int OPC_LSB = 6;
    localparam int CMD_MSB = 8;
    localparam int CMD_LSB = 2;
    localparam int RD_MSB  = 1;
    localparam int RD_LSB  = 0;
    localparam int IMM_MSB = 5;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        OP_ALU0 = 3'b000,
        OP_LI   = 3'b001,
        OP_BZ   = 3'b010,
        OP_HALT = 3'b011
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_DONE
    } state_e;

    typedef struct packed {
        logic [6:0] alu_cmd;
        logic       li;
        logic       alu_src;
        logic [1:0] reg_dst;
        logic [7:0] imm;
        logic       writes_reg;
        logic       is_branch;
        logic       is_halt;
        logic       updates_flags;
        logic       updates_carry;
    } ctrl_t;

    // Opcodes 000 and 1xx all belong to the ALU class.
    function automatic logic is_alu_class(input logic [2:0] opc);
        return (opc == OP_ALU0) || opc[2];
    endfunction

endpackage

// File: rtl/ctrl_sequencer_decode.sv
// Combinational instruction decoder: 9-bit instruction to control bundle.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [8:0] instr_i,
    output ctrl_t      ctrl_o
);

    logic [2:0] opc;
    assign opc = instr_i[OPC_MSB:OPC_LSB];

    always_comb begin
        ctrl_o = '0;
        if (is_alu_class(opc)) begin
            ctrl_o.alu_cmd       = instr_i[CMD_MSB:CMD_LSB];
            ctrl_o.reg_dst       = instr_i[RD_MSB:RD_LSB];
            ctrl_o.writes_reg    = 1'b1;
            ctrl_o.updates_flags = 1'b1;
            ctrl_o.updates_carry = 1'b1;
        end else begin
            case (opc)
                OP_LI: begin
                    ctrl_o.li            = 1'b1;
                    ctrl_o.alu_src       = 1'b1;
                    ctrl_o.imm           = {2'b00, instr_i[IMM_MSB:IMM_LSB]};
                    ctrl_o.writes_reg    = 1'b1;
                    ctrl_o.updates_flags = 1'b1;
                end
                OP_BZ:   ctrl_o.is_branch = 1'b1;
                OP_HALT: ctrl_o.is_halt   = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Four-cycle fetch/decode/exec/writeback sequencer driving the ALU control
// interface, owning the PC, instruction register and zero/carry flags.
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int PC_W = 10,
    parameter int IW   = 9
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [IW-1:0]   instr_i,
    input  logic            zero_i,
    input  logic            sc_o_i,
    output logic [PC_W-1:0] pc_o,
    output logic [6:0]      alu_cmd,
    output logic            li,
    output logic            ALUSrc,
    output logic [1:0]      regDst,
    output logic            sc_i,
    output logic [7:0]      imm_o,
    output logic            reg_we,
    output logic            done
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [IW-1:0]   ir_q, ir_d;
    logic            zero_q, zero_d;
    logic            carry_q, carry_d;
    ctrl_t           dec;
    logic [PC_W-1:0] br_off;

    ctrl_decode u_decode (
        .instr_i (ir_q),
        .ctrl_o  (dec)
    );

    assign br_off = {{(PC_W-6){ir_q[5]}}, ir_q[5:0]};
    assign pc_o   = pc_q;
    assign sc_i   = carry_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        alu_cmd = '0;
        li      = 1'b0;
        ALUSrc  = 1'b0;
        regDst  = '0;
        imm_o   = '0;
        reg_we  = 1'b0;
        done    = 1'b0;

        // Control outputs are only live while the latched instruction executes.
        if (state_q == S_EXEC || state_q == S_WB) begin
            alu_cmd = dec.alu_cmd;
            li      = dec.li;
            ALUSrc  = dec.alu_src;
            regDst  = dec.reg_dst;
            imm_o   = dec.imm;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                ir_d    = instr_i;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (dec.is_halt) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WB;
                    if (dec.updates_flags) zero_d  = zero_i;
                    if (dec.updates_carry) carry_d = sc_o_i;
                end
            end
            S_WB: begin
                reg_we  = dec.writes_reg;
                pc_d    = (dec.is_branch && zero_q) ? pc_q + br_off : pc_q + 1'b1;
                state_d = S_FETCH;
            end
            S_DONE: begin
                done = 1'b1;
                if (!start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: directed vector table, HALT and
// reset corner sequences, then random instructions against an ISA-level model.
module tb_ctrl_sequencer;

    logic       clk = 1'b0;
    logic       reset, start, zero_i, sc_o_i;
    logic [8:0] instr_i;
    logic [9:0] pc_o;
    logic [6:0] alu_cmd;
    logic       li, ALUSrc, sc_i, reg_we, done;
    logic [1:0] regDst;
    logic [7:0] imm_o;
    logic [18:0] ctl_v;

    ctrl_sequencer #(.PC_W(10), .IW(9)) dut (
        .clk(clk), .reset(reset), .start(start), .instr_i(instr_i),
        .zero_i(zero_i), .sc_o_i(sc_o_i), .pc_o(pc_o), .alu_cmd(alu_cmd),
        .li(li), .ALUSrc(ALUSrc), .regDst(regDst), .sc_i(sc_i),
        .imm_o(imm_o), .reg_we(reg_we), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous instruction ROM: data valid one cycle after the address.
    logic [8:0] mem [0:1023];
    always @(posedge clk) instr_i <= mem[pc_o];

    assign ctl_v = {alu_cmd, li, ALUSrc, regDst, imm_o};

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    function automatic logic [18:0] mk(input logic [6:0] a, input logic l,
                                       input logic [1:0] r, input logic [7:0] im);
        return {a, l, l, r, im};
    endfunction

    // Called on the negedge inside FETCH; returns on the negedge of the next FETCH.
    task automatic run_instr(input logic [8:0] ins, input logic zin, input logic scin,
                             input logic [18:0] e_ctl, input logic e_we,
                             input int pc_cur, input logic c_before, input logic c_after);
        chk("fetch_pc", pc_o, pc_cur);
        chk("fetch_ctl", ctl_v, 0);
        chk("fetch_we", reg_we, 0);
        chk("fetch_done", done, 0);
        mem[pc_cur] = ins;
        start = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("decode_ctl", ctl_v, 0);
        chk("decode_we", reg_we, 0);
        @(negedge clk);
        chk("exec_ctl", ctl_v, e_ctl);
        chk("exec_we", reg_we, 0);
        chk("exec_sc", sc_i, c_before);
        zero_i = zin;
        sc_o_i = scin;
        @(negedge clk);
        chk("wb_ctl", ctl_v, e_ctl);
        chk("wb_we", reg_we, e_we);
        chk("wb_sc", sc_i, c_after);
        @(negedge clk);
    endtask

    // Instruction-level reference model.
    int   m_pc;
    logic m_zero, m_carry;

    task automatic run_model(input logic [8:0] ins, input logic zin, input logic scin);
        int   op, off, nxt;
        logic alu, isli, isbz, c_after, z_after;
        op   = int'(ins) / 64;
        alu  = (op == 0) || (op >= 4);
        isli = (op == 1);
        isbz = (op == 2);
        off  = int'(ins) % 64;
        if (off >= 32) off -= 64;
        nxt     = (isbz && m_zero) ? (m_pc + off + 1024) % 1024 : (m_pc + 1) % 1024;
        c_after = alu ? scin : m_carry;
        z_after = (alu || isli) ? zin : m_zero;
        run_instr(ins, zin, scin,
                  mk(alu ? 7'(int'(ins) / 4) : 7'd0, isli,
                     alu ? 2'(int'(ins) % 4) : 2'd0, isli ? 8'(int'(ins) % 64) : 8'd0),
                  alu || isli, m_pc, m_carry, c_after);
        m_pc    = nxt;
        m_zero  = z_after;
        m_carry = c_after;
    endtask

    typedef struct {
        logic [8:0]  ins;
        logic        zin;
        logic        scin;
        logic [18:0] e_ctl;
        logic        e_we;
        int          e_next;
        logic        e_carry;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int   pc_cur;
        logic carry;
        for (int i = 0; i < 1024; i++) mem[i] = '0;

        tbl[0] = '{9'b000_0001_01, 1'b0, 1'b0, mk(7'h01, 1'b0, 2'd1, 8'h00), 1'b1, 1, 1'b0};
        tbl[1] = '{9'b001_101010,  1'b1, 1'b1, mk(7'h00, 1'b1, 2'd0, 8'h2A), 1'b1, 2, 1'b0};
        tbl[2] = '{9'b100_0000_10, 1'b0, 1'b1, mk(7'h40, 1'b0, 2'd2, 8'h00), 1'b1, 3, 1'b1};
        tbl[3] = '{9'b001_000001,  1'b1, 1'b0, mk(7'h00, 1'b1, 2'd0, 8'h01), 1'b1, 4, 1'b1};
        tbl[4] = '{9'b010_000001,  1'b0, 1'b0, mk(7'h00, 1'b0, 2'd0, 8'h00), 1'b0, 5, 1'b1};
        tbl[5] = '{9'b010_111110,  1'b0, 1'b0, mk(7'h00, 1'b0, 2'd0, 8'h00), 1'b0, 3, 1'b1};
        tbl[6] = '{9'b000_0000_11, 1'b0, 1'b0, mk(7'h00, 1'b0, 2'd3, 8'h00), 1'b1, 4, 1'b0};
        tbl[7] = '{9'b010_000011,  1'b1, 1'b1, mk(7'h00, 1'b0, 2'd0, 8'h00), 1'b0, 5, 1'b0};
        tbl[8] = '{9'b010_111110,  1'b1, 1'b1, mk(7'h00, 1'b0, 2'd0, 8'h00), 1'b0, 6, 1'b0};
        tbl[9] = '{9'b111_1111_00, 1'b1, 1'b1, mk(7'h7F, 1'b0, 2'd0, 8'h00), 1'b1, 7, 1'b1};

        reset = 1'b1; start = 1'b0; zero_i = 1'b0; sc_o_i = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_pc", pc_o, 0);
        chk("rst_ctl", ctl_v, 0);
        chk("rst_we", reg_we, 0);
        chk("rst_done", done, 0);
        chk("rst_sc", sc_i, 0);
        start = 1'b1;
        @(negedge clk);

        pc_cur = 0;
        carry  = 1'b0;
        foreach (tbl[i]) begin
            run_instr(tbl[i].ins, tbl[i].zin, tbl[i].scin, tbl[i].e_ctl, tbl[i].e_we,
                      pc_cur, carry, tbl[i].e_carry);
            pc_cur = tbl[i].e_next;
            carry  = tbl[i].e_carry;
        end

        // HALT at PC 7 with start held high, then release and restart.
        chk("halt_pc", pc_o, 7);
        mem[7] = 9'b011_000000;
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("halt_exec_ctl", ctl_v, 0);
        chk("halt_exec_we", reg_we, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("halt_done", done, 1);
            chk("halt_pc_hold", pc_o, 7);
            chk("halt_we", reg_we, 0);
        end
        start = 1'b0;
        @(negedge clk);
        chk("idle_done", done, 0);
        chk("idle_pc", pc_o, 7);
        start = 1'b1;
        @(negedge clk);
        chk("restart_pc", pc_o, 0);

        // Reset in the middle of EXEC of an ALU op.
        mem[0] = 9'b000_0001_01;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_ctl", ctl_v, mk(7'h01, 1'b0, 2'd1, 8'h00));
        chk("pre_rst_sc", sc_i, 1);
        zero_i = 1'b1; sc_o_i = 1'b1;
        reset = 1'b1;
        #1;
        chk("mid_rst_ctl", ctl_v, 0);
        chk("mid_rst_we", reg_we, 0);
        chk("mid_rst_pc", pc_o, 0);
        chk("mid_rst_sc", sc_i, 0);
        @(negedge clk);
        chk("mid_rst_we2", reg_we, 0);
        reset = 1'b0; start = 1'b1;
        @(negedge clk);

        m_pc = 0; m_zero = 1'b0; m_carry = 1'b0;
        run_model(9'b010_000101, 1'b0, 1'b0);   // zero cleared by reset: not taken
        run_model(9'b001_010101, 1'b1, 1'b0);   // sets zero
        run_model(9'b010_111101, 1'b0, 1'b0);   // 2 - 3 wraps to 1023
        run_model(9'b000_0000_10, 1'b0, 1'b1);  // 1023 + 1 wraps to 0
        for (int n = 0; n < 150; n++) begin
            int op;
            op = $urandom_range(0, 7);
            if (op == 3) op = 0;
            run_model(9'(op * 64 + $urandom_range(0, 63)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
